// File: rtl/pwm_seq_pkg.sv
// Shared types and widths for the PWM pattern sequencer.
package pwm_seq_pkg;

  localparam int PKG_STEPS = 4;
  localparam int PKG_CNT_W = 16;
  localparam int PKG_REP_W = 8;
  localparam int PKG_IDX_W = $clog2(PKG_STEPS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  // One pattern table entry: period and hold in timebase ticks, plus repeat count.
  typedef struct packed {
    logic [PKG_CNT_W-1:0] period;
    logic [PKG_CNT_W-1:0] hold;
    logic [PKG_REP_W-1:0] reps;
  } step_t;

  // A repeat count of zero plays the step once.
  function automatic logic [PKG_REP_W-1:0] eff_reps(input logic [PKG_REP_W-1:0] reps);
    return (reps == '0) ? PKG_REP_W'(1) : reps;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// Single PWM channel: prescaled timebase, phase counter and registered pwm compare.
module pwm_channel
#(
  parameter int PRESCALE_TICKS = 600,
  parameter int CNT_W          = 16
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] per,
  input  logic [CNT_W-1:0] hold,
  output logic             pwm,
  output logic             tick,
  output logic             period_wrap
);

  localparam int             PS_W    = $clog2(PRESCALE_TICKS + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_TICKS - 1);

  logic [PS_W-1:0]  presc;
  logic [PS_W-1:0]  presc_nxt;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] phase_nxt;

  assign tick        = (presc == PS_LAST);
  // per is nonzero whenever the channel is enabled, so per-1 does not underflow in use.
  assign period_wrap = tick && (phase == per - CNT_W'(1));

  // Next prescaler and phase values while the channel is running.
  always_comb begin
    presc_nxt = tick ? '0 : presc + PS_W'(1);
    phase_nxt = phase;
    if (tick) begin
      phase_nxt = period_wrap ? '0 : phase + CNT_W'(1);
    end
  end

  // Counters and the registered output; load primes phase 0 so the first run cycle is already valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      phase <= '0;
      pwm   <= 1'b0;
    end else if (clear) begin
      presc <= '0;
      phase <= '0;
      pwm   <= 1'b0;
    end else if (load) begin
      presc <= '0;
      phase <= '0;
      pwm   <= (hold != '0);
    end else if (enable) begin
      presc <= presc_nxt;
      phase <= phase_nxt;
      pwm   <= (phase_nxt < hold);
    end
  end

endmodule

// File: rtl/pwm_sequencer.sv
// Runtime-programmable PWM pattern player: walks a table of {period, hold, reps} steps.
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int PRESCALE_TICKS = 600,
  parameter int STEPS          = PKG_STEPS,
  parameter int CNT_W          = PKG_CNT_W,
  parameter int REP_W          = PKG_REP_W
)
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     cfg_we,
  input  logic [$clog2(STEPS)-1:0] cfg_addr,
  input  logic [CNT_W-1:0]         cfg_period,
  input  logic [CNT_W-1:0]         cfg_hold,
  input  logic [REP_W-1:0]         cfg_reps,
  output logic                     pwm,
  output logic                     busy,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     done
);

  localparam int IDX_W = $clog2(STEPS);

  step_t            step_tab [STEPS];
  step_t            entry;
  state_t           state;

  logic [CNT_W-1:0] per_w;
  logic [CNT_W-1:0] hold_w;
  logic [REP_W-1:0] reps_w;
  logic [REP_W-1:0] rep_cnt;

  logic             tick;
  logic             period_wrap;
  logic             wrap;
  logic             rep_last;
  logic             last_step;
  logic             zero_entry;
  logic             restart;
  logic [IDX_W-1:0] last_idx;

  logic             ch_clear;
  logic             ch_load;
  logic             ch_enable;
  logic [CNT_W-1:0] ch_hold;

  // Sequencing decisions derived from the current state and the addressed table entry.
  always_comb begin
    entry      = step_tab[step_idx];
    wrap       = (state == RUN) && tick && period_wrap;
    rep_last   = (rep_cnt == reps_w - REP_W'(1));
    last_step  = (step_idx == IDX_W'(STEPS - 1));
    zero_entry = (state == LOAD) && (entry.period == '0);
    // A zero-period entry at step 0 would reload forever, so it always finishes instead.
    restart    = loop_en && !(zero_entry && (step_idx == '0));
    // A zero-period terminator was never played; report the step before it.
    last_idx   = (zero_entry && (step_idx != '0)) ? step_idx - IDX_W'(1) : step_idx;

    ch_clear  = 1'b0;
    ch_load   = 1'b0;
    ch_enable = 1'b0;
    case (state)
      LOAD: begin
        if (!stop && (entry.period != '0)) ch_load  = 1'b1;
        else                               ch_clear = 1'b1;
      end
      RUN: begin
        if (stop || (wrap && rep_last)) ch_clear  = 1'b1;
        else                            ch_enable = 1'b1;
      end
      default: ch_clear = 1'b1;
    endcase
    // During LOAD the channel primes from the entry being loaded, afterwards from the working copy.
    ch_hold = (state == LOAD) ? entry.hold : hold_w;
  end

  // Pattern table; written at any time, never reset.
  always_ff @(posedge clk) begin
    if (cfg_we && (int'(cfg_addr) < STEPS)) begin
      step_tab[cfg_addr] <= '{period: cfg_period, hold: cfg_hold, reps: cfg_reps};
    end
  end

  // Working copy of the active step, captured at LOAD so table writes only affect later loads.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      per_w  <= entry.period;
      hold_w <= entry.hold;
      reps_w <= eff_reps(entry.reps);
    end
  end

  // Sequencer FSM: start/stop handling, step advance, looping and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= '0;
      rep_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rep_cnt <= '0;
          if (start && !stop) begin
            state    <= LOAD;
            busy     <= 1'b1;
            step_idx <= '0;
          end
        end
        LOAD: begin
          rep_cnt <= '0;
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (entry.period != '0) begin
            state <= RUN;
          end else if (restart) begin
            state    <= LOAD;
            step_idx <= '0;
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            step_idx <= last_idx;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wrap) begin
            if (!rep_last) begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end else begin
              rep_cnt <= '0;
              if (!last_step) begin
                state    <= LOAD;
                step_idx <= step_idx + IDX_W'(1);
              end else if (restart) begin
                state    <= LOAD;
                step_idx <= '0;
              end else begin
                state    <= IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                step_idx <= last_idx;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  pwm_channel #(
    .PRESCALE_TICKS (PRESCALE_TICKS),
    .CNT_W          (CNT_W)
  ) u_channel (
    .clk         (clk),
    .reset       (reset),
    .clear       (ch_clear),
    .load        (ch_load),
    .enable      (ch_enable),
    .per         (per_w),
    .hold        (ch_hold),
    .pwm         (pwm),
    .tick        (tick),
    .period_wrap (period_wrap)
  );

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer: step-level expected-waveform model plus directed scenarios.
module tb_pwm_sequencer;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_hold = '0;
  logic [7:0]  cfg_reps = '0;
  logic        pwm;
  logic        busy;
  logic [1:0]  step_idx;
  logic        done;

  pwm_sequencer #(
    .PRESCALE_TICKS (P),
    .STEPS          (4),
    .CNT_W          (16),
    .REP_W          (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_period (cfg_period),
    .cfg_hold   (cfg_hold),
    .cfg_reps   (cfg_reps),
    .pwm        (pwm),
    .busy       (busy),
    .step_idx   (step_idx),
    .done       (done)
  );

  initial forever #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model: expands each step into its expected pwm waveform ----------------
  typedef struct packed {
    logic [15:0] period;
    logic [15:0] hold;
    logic [7:0]  reps;
  } ent_t;

  ent_t       mtab [4];
  bit         m_active = 1'b0;
  bit         m_load = 1'b0;
  int         m_k = 0;
  bit         runq [$];
  logic       e_pwm = 1'b0;
  logic       e_busy = 1'b0;
  logic       e_done = 1'b0;
  logic [1:0] e_idx = '0;

  task automatic m_end(input bit zero);
    if (loop_en && !(zero && m_k == 0)) begin
      m_k = 0; m_load = 1'b1;
      e_pwm = 1'b0; e_busy = 1'b1; e_idx = 2'd0;
    end else begin
      m_active = 1'b0;
      e_pwm = 1'b0; e_busy = 1'b0; e_done = 1'b1;
      e_idx = (zero && m_k > 0) ? 2'(m_k - 1) : 2'(m_k);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_active = 1'b0; m_load = 1'b0; m_k = 0; runq.delete();
      e_pwm = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_idx = '0;
    end else begin
      e_done = 1'b0;
      if (!m_active) begin
        e_pwm = 1'b0; e_busy = 1'b0;
        if (start && !stop) begin
          m_active = 1'b1; m_k = 0; m_load = 1'b1; e_busy = 1'b1; e_idx = 2'd0;
        end
      end else if (stop) begin
        m_active = 1'b0; runq.delete(); e_pwm = 1'b0; e_busy = 1'b0;
      end else if (m_load) begin
        ent_t e;
        int   n;
        int   per_clks;
        e = mtab[m_k];
        if (e.period == 0) m_end(1'b1);
        else begin
          n = (e.reps == 0) ? 1 : int'(e.reps);
          per_clks = int'(e.period) * P;
          for (int r = 0; r < n; r++)
            for (int i = 0; i < per_clks; i++) runq.push_back((i / P) < int'(e.hold));
          m_load = 1'b0; e_busy = 1'b1; e_pwm = runq.pop_front();
        end
      end else if (runq.size() == 0) begin
        if (m_k == 3) m_end(1'b0);
        else begin
          m_k++; m_load = 1'b1; e_pwm = 1'b0; e_idx = 2'(m_k);
        end
      end else begin
        e_pwm = runq.pop_front();
      end
      // Table writes land after this edge's LOAD decision, like the hardware.
      if (cfg_we) mtab[cfg_addr] = '{cfg_period, cfg_hold, cfg_reps};
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en)
      chk("cycle", 32'({pwm, busy, done, step_idx}), 32'({e_pwm, e_busy, e_done, e_idx}));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg_write(input int addr, input int per, input int hold, input int reps);
    cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_period = 16'(per); cfg_hold = 16'(hold); cfg_reps = 8'(reps);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Single-step pattern {3,1,2} then terminator; literal timeline from cycle 0 (start).
  task automatic run_single(input string tag);
    start = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      chk({tag, " pwm"},  32'(pwm),  32'((c >= 2 && c <= 5) || (c >= 14 && c <= 17)));
      chk({tag, " busy"}, 32'(busy), 32'(c >= 1 && c <= 26));
      chk({tag, " done"}, 32'(done), 32'(c == 27));
    end
  endtask

  int cnt_a;
  int cnt_b;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst pwm", 32'(pwm), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst idx", 32'(step_idx), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Single-step pattern
    cfg_write(0, 3, 1, 2);
    cfg_write(1, 0, 0, 0);
    cfg_write(2, 2, 1, 1);
    cfg_write(3, 2, 1, 1);
    loop_en = 1'b0;
    run_single("s2");

    // Asynchronous reset in the middle of RUN, then the same table replays
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    chk("s1 pwm", 32'(pwm), 32'd0);
    chk("s1 busy", 32'(busy), 32'd0);
    chk("s1 done", 32'(done), 32'd0);
    chk("s1 idx", 32'(step_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_single("s1b");

    // Full table, non-looping
    for (int a = 0; a < 4; a++) cfg_write(a, 2, 1, 1);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 10) begin
        chk("s3 load idx", 32'(step_idx), 32'd1);
        chk("s3 load pwm", 32'(pwm), 32'd0);
      end
      if (c == 11) chk("s3 run pwm", 32'(pwm), 32'd1);
      if (c == 37) begin
        chk("s3 done", 32'(done), 32'd1);
        chk("s3 done idx", 32'(step_idx), 32'd3);
      end
      if (c == 38) chk("s3 done pulse", 32'(done), 32'd0);
    end

    // Looping, then stop
    loop_en = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 37) begin
        chk("s4 wrap idx", 32'(step_idx), 32'd0);
        chk("s4 wrap busy", 32'(busy), 32'd1);
        chk("s4 wrap done", 32'(done), 32'd0);
      end
      if (c == 38) chk("s4 wrap pwm", 32'(pwm), 32'd1);
      if (c == 45) stop = 1'b1;
      if (c == 46) begin
        stop = 1'b0;
        chk("s4 stop pwm", 32'(pwm), 32'd0);
        chk("s4 stop busy", 32'(busy), 32'd0);
        chk("s4 stop done", 32'(done), 32'd0);
      end
    end

    // Edge duty values
    loop_en = 1'b0;
    cfg_write(0, 3, 5, 1);
    cfg_write(1, 3, 0, 1);
    cfg_write(2, 2, 1, 0);
    cfg_write(3, 0, 0, 0);
    cnt_a = 0;
    cnt_b = 0;
    start = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c >= 2 && c <= 13 && pwm === 1'b1) cnt_a++;
      if (c >= 15 && c <= 26 && pwm === 1'b1) cnt_b++;
      if (c == 28) chk("s5 reps0 hi", 32'(pwm), 32'd1);
      if (c == 32) chk("s5 reps0 lo", 32'(pwm), 32'd0);
      if (c == 37) chk("s5 done", 32'(done), 32'd1);
    end
    chk("s5 hold>per highs", 32'(cnt_a), 32'd12);
    chk("s5 hold0 highs", 32'(cnt_b), 32'd0);

    // Contention: start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("s6 start+stop busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("s6 still idle", 32'(busy), 32'd0);

    // Table writes during playback, including one in the same cycle as a LOAD
    for (int a = 0; a < 4; a++) cfg_write(a, 2, 1, 1);
    loop_en = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 84; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 12) begin
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_period = 16'd3; cfg_hold = 16'd3; cfg_reps = 8'd1;
      end
      if (c == 13) cfg_we = 1'b0;
      if (c == 15) chk("s6 step1 old", 32'(pwm), 32'd0);
      if (c == 37) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_period = 16'd1; cfg_hold = 16'd0; cfg_reps = 8'd1;
      end
      if (c == 38) begin
        cfg_we = 1'b0;
        chk("s6 load old", 32'(pwm), 32'd1);
      end
      if (c == 47) chk("s6 step1 new a", 32'(pwm), 32'd1);
      if (c == 51) chk("s6 step1 new b", 32'(pwm), 32'd1);
      if (c == 78) begin
        chk("s6 step0 new pwm", 32'(pwm), 32'd0);
        chk("s6 step0 new busy", 32'(busy), 32'd1);
        chk("s6 step0 new idx", 32'(step_idx), 32'd0);
      end
      if (c == 80) stop = 1'b1;
      if (c == 81) begin
        stop = 1'b0;
        chk("s6 stop busy", 32'(busy), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_sequencer.md
Name: pwm_sequencer

Overview:
- Plays a programmable PWM pattern on one output.
- Pattern is a table of STEPS entries. Each entry holds period, hold and repeat count.
- Steps run in order from a shared prescaled timebase. An entry with period 0 ends the pattern; optional looping restarts it.
- Sits above the fixed PWM timers: status LEDs, blink codes and buzzer cadences are reprogrammed at runtime with no resynthesis.

Parameters:
- PRESCALE_TICKS, 600, clk cycles per timebase tick (25 us at 24 MHz); must be >= 1.
- STEPS, 4, number of pattern table entries; must be >= 2.
- CNT_W, 16, width of period and hold fields, in ticks.
- REP_W, 8, width of repeat-count field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin pattern at step 0; sampled only in IDLE.
- stop  in  1  abort pattern; sampled in any state.
- loop_en  in  1  1: wrap to step 0 after the last step; 0: finish with done.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  $clog2(STEPS)  table entry index.
- cfg_period  in  CNT_W  ticks per PWM period; 0 marks end of pattern.
- cfg_hold  in  CNT_W  ticks pwm is high within each period.
- cfg_reps  in  REP_W  periods to play for this step; 0 is treated as 1.
- pwm  out  1  PWM output (registered).
- busy  out  1  high in LOAD and RUN.
- step_idx  out  $clog2(STEPS)  index of the current or last-played step.
- done  out  1  one-cycle pulse when a non-looping pattern completes.

Behaviour:
- Reset (async, reset high):
  - pwm=0, busy=0, done=0, step_idx=0, state=IDLE.
  - Prescaler, phase and repeat counters cleared to 0.
  - Table contents are not reset.
- States: IDLE, LOAD, RUN.
- IDLE:
  - start=1 and stop=0 -> LOAD next cycle, step_idx=0.
  - start and stop high in the same cycle: stop wins, stay in IDLE.
  - start is ignored outside IDLE.
- LOAD (exactly 1 cycle):
  - Copy table[step_idx] into working registers: per, hold, reps (reps 0 -> 1).
  - Clear prescaler, phase and repeat counters; pwm=0.
  - If the copied period is 0: go to end handling (below) without entering RUN.
  - Otherwise -> RUN.
- RUN:
  - Prescaler counts 0..PRESCALE_TICKS-1 and raises tick on its last count.
  - On tick, phase counts 0..per-1, then wraps.
  - pwm is registered: pwm = (phase < hold), so the first RUN cycle drives high when hold > 0.
  - hold >= per -> constant 1. hold = 0 -> constant 0.
  - Each period lasts exactly per*PRESCALE_TICKS clocks.
  - On the tick that wraps phase, increment the repeat counter.
  - When the repeat counter reaches reps: advance to step_idx+1 and go to LOAD. The inter-step LOAD cycle has pwm=0 (accepted 1-clock gap).
- End handling (step_idx was STEPS-1, or the loaded entry has period 0):
  - loop_en=1 -> step_idx=0, LOAD.
  - loop_en=0 -> IDLE, done=1 for that one cycle, busy=0, pwm=0, step_idx holds the last played index.
  - Period 0 at step 0 with loop_en=1: go to IDLE with done=1 (no infinite LOAD loop).
- stop=1 in LOAD or RUN: next cycle state=IDLE, pwm=0, busy=0, no done pulse. The next start begins at step 0.
- Table writes:
  - Accepted in any state.
  - Running from working copies, so a write to the active step takes effect at that step's next LOAD.
  - A write landing in the same cycle as a LOAD of the same address: LOAD captures the old value.
- Counter arithmetic is unsigned and uses no wrap-around beyond the compares above. The prescaler width is $clog2(PRESCALE_TICKS+1).

Decomposition:
- Package pwm_seq_pkg holds:
  - state enum {IDLE, LOAD, RUN}
  - step record typedef {period, hold, reps}
  - width localparams derived from CNT_W, REP_W, STEPS
- Sub-module pwm_channel contains:
  - prescaler and phase counter
  - runtime per/hold inputs
  - clear input
  - outputs: pwm, tick, period_wrap
- The sequencer FSM and table stay in pwm_sequencer.

Test Plan:
All scenarios use PRESCALE_TICKS=4, STEPS=4.
1. Reset mid-RUN -> pwm=0, busy=0, done=0, step_idx=0 immediately (asynchronous). Table contents unchanged afterwards.
2. Single-step pattern:
   - Setup: table[0]={3,1,2}, table[1].period=0, loop_en=0.
   - Stimulus: start pulse at cycle 0.
   - Required: busy=1 from cycle 1. pwm high cycles 2-5, low 6-13, high 14-17, low 18-25.
   - Required: LOAD of step 1 at cycle 26; done=1 at cycle 27; busy=0 at cycle 27.
3. Full table, non-looping:
   - Setup: all 4 steps {2,1,1}, loop_en=0.
   - Required: step_idx sequence 0,1,2,3 with one pwm-low LOAD cycle between steps. done after step 3, with step_idx=3.
4. Looping:
   - Setup: same table, loop_en=1.
   - Required: after step 3, step_idx=0 and playback continues; done never asserts. stop -> pwm=0, busy=0 next cycle, no done.
5. Edge duty values:
   - hold=5, period=3 -> pwm constant 1 through RUN.
   - hold=0 -> pwm constant 0.
   - reps=0 plays exactly 1 period.
6. Contention:
   - start and stop in the same IDLE cycle -> stays IDLE.
   - Write to table[1] while step 1 runs -> current step unchanged; new values used on the next loop pass.
